vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator that produces the scan coordinates, pixel strobe and sync pulses consumed by the text painters and the other pixel-domain blocks of the TicTacToe display. It divides the system clock into a pixel-rate strobe and runs horizontal and vertical counters over a 640x480 @ 60 Hz VGA frame. It drives `pix_x`, `pix_y`, `pixel_tick` and `video_on` to the painters, and `hsync_n`/`vsync_n` to the connector. Optionally, it derives a once-per-second strobe for timer and blink logic.

## Interface
- `TICK_DIV`, 2: system clocks per pixel (≥2).
- `H_DISPLAY`, 640; `H_FRONT`, 16; `H_RETRACE`, 96; `H_BACK`, 48: horizontal pixel counts.
- `V_DISPLAY`, 480; `V_FRONT`, 10; `V_RETRACE`, 2; `V_BACK`, 33: vertical line counts.
- `FRAMES_PER_SEC`, 60: frames per `sec_tick`; used only with the macro.

Ports:
- `clk` in 1: system clock (50 MHz).
- `reset_n` in 1: asynchronous, active-low reset.
- `pixel_tick` out 1: one-`clk` strobe at pixel rate.
- `pix_x` out 10: horizontal count, range 0..H_TOTAL-1, where H_TOTAL=800.
- `pix_y` out 10: vertical count, range 0..V_TOTAL-1, where V_TOTAL=525.
- `video_on` out 1: high while inside the visible area.
- `hsync_n` out 1: horizontal sync, active-low, registered.
- `vsync_n` out 1: vertical sync, active-low, registered.
- `frame_tick` out 1: one-`clk` pulse on the last pixel of each frame.
- `sec_tick` out 1: one-`clk` pulse every FRAMES_PER_SEC frames.

## Operation
- Divider `div` counts 0..TICK_DIV-1 and wraps.
  - `pixel_tick = (div == TICK_DIV-1)`; this is combinational.
- On a `clk` edge with `pixel_tick`=1:
  - `h` increments.
  - At H_TOTAL-1, `h` wraps to 0 and `v` increments.
  - `v` wraps to 0 at V_TOTAL-1.
  - In all other cycles, both counters hold.
- `pix_x = h` and `pix_y = v`, driven directly from the registers.
- `video_on = (h < H_DISPLAY) && (v < V_DISPLAY)`; this is combinational.
- `hsync_n` is low iff `h` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_RETRACE-1], i.e. 656..751.
- `vsync_n` is low iff `v` is in [490, 491].
- Both sync registers load from the next-state counter values, so they change on the same edge as `pix_x`/`pix_y` (zero skew, glitch-free).
- `frame_tick = pixel_tick && h==H_TOTAL-1 && v==V_TOTAL-1`.
- Frame rate: 25 MHz / (800·525) ≈ 59.52 Hz.

## Timing
- Reset values: `div`=0, `h`=0, `v`=0, `pixel_tick`=0, `pix_x`=0, `pix_y`=0, `video_on`=1, `hsync_n`=1, `vsync_n`=1, `frame_tick`=0, `sec_tick`=0.
- Reset asserted mid-frame: all registers clear immediately (asynchronously).
  - On release, the first `pixel_tick` occurs in the TICK_DIV-th `clk` cycle.
  - The first counter advance happens on that cycle's closing edge.
- `pixel_tick` period is exactly TICK_DIV clocks, with duty 1/TICK_DIV.
- Sync and `video_on` change only on edges where `pixel_tick`=1.
- Line length is 800 ticks; frame length is 420000 ticks (840000 `clk` at TICK_DIV=2).
- `hsync_n` is low for 96 ticks per line; `vsync_n` is low for 2 full lines (1600 ticks) per frame.
- Simultaneous h-wrap and v-wrap: both counters become 0 on the same edge, coincident with `frame_tick`.

## Configuration
- `VGA_SYNC_SECOND_TICK_EN` defined:
  - Frame counter `fc` (6 bits at the default) increments on `frame_tick`.
  - `fc` wraps at FRAMES_PER_SEC-1 and resets to 0.
  - `sec_tick = frame_tick && fc==FRAMES_PER_SEC-1` (≈1.008 s period).
- Undefined: the frame counter is absent and `sec_tick` is tied to 0. The port is always present.

## Test plan
- Reset → all outputs at their listed reset values; after release, first `pixel_tick` in cycle 2 (TICK_DIV=2); `pix_x`=1 after that edge.
- Run one line → `hsync_n` falls when `pix_x` becomes 656 and rises when `pix_x` becomes 752 (96 ticks); `video_on` falls when `pix_x` becomes 640.
- Run one frame → `vsync_n` is low exactly while `pix_y` is 490..491; `frame_tick` occurs once, at `pix_x`=799, `pix_y`=524; next frame starts at (0,0) 840000 `clk` after the first.
- Assert `reset_n` low mid-line at `pix_x`=700 (sync active) → `hsync_n` returns to 1 and counters to 0 asynchronously, without waiting for `clk`.
- With `VGA_SYNC_SECOND_TICK_EN`, run 120 frames → exactly 2 `sec_tick` pulses, each coincident with the 60th and 120th `frame_tick`; without the macro, `sec_tick` stays 0.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel strobe, scan counters and sync pulses for a 640x480 @ 60 Hz
// VGA frame. The system clock is divided by TICK_DIV to form the pixel strobe.
// Optional feature macro: VGA_SYNC_SECOND_TICK_EN adds a frame counter that
// produces a once-per-second strobe on sec_tick. Without it sec_tick is tied low.
module vga_sync_gen #(
  parameter int TICK_DIV       = 2,
  parameter int H_DISPLAY      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_RETRACE      = 96,
  parameter int H_BACK         = 48,
  parameter int V_DISPLAY      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_RETRACE      = 2,
  parameter int V_BACK         = 33,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pixel_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_tick,
  output logic       sec_tick
);

  localparam int DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hsync_n;
  logic             r_vsync_n;
  logic [9:0]       w_h_next;
  logic [9:0]       w_v_next;
  logic             w_tick;
  logic             w_frame_tick;

  assign w_tick = (r_div == DIV_LAST);

  // Pixel-rate divider: counts 0..TICK_DIV-1, the last count is the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Next-state scan position; holds unless the pixel strobe is active.
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_tick) begin
      if (r_h == H_LAST) begin
        w_h_next = '0;
        if (r_v == V_LAST) begin
          w_v_next = '0;
        end else begin
          w_v_next = r_v + 10'd1;
        end
      end else begin
        w_h_next = r_h + 10'd1;
      end
    end
  end

  // Counters and syncs share one edge: syncs decode the next position so they
  // line up with pix_x/pix_y with no skew and come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h       <= '0;
      r_v       <= '0;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
    end else begin
      r_h       <= w_h_next;
      r_v       <= w_v_next;
      r_hsync_n <= !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
      r_vsync_n <= !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
    end
  end

  assign w_frame_tick = w_tick && (r_h == H_LAST) && (r_v == V_LAST);

  assign pixel_tick = w_tick;
  assign pix_x      = r_h;
  assign pix_y      = r_v;
  assign video_on   = (r_h < H_VIS) && (r_v < V_VIS);
  assign hsync_n    = r_hsync_n;
  assign vsync_n    = r_vsync_n;
  assign frame_tick = w_frame_tick;

`ifdef VGA_SYNC_SECOND_TICK_EN
  localparam int FC_W = (FRAMES_PER_SEC > 2) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

  logic [FC_W-1:0] r_fc;

  // Frame counter: advances once per frame, wraps after FRAMES_PER_SEC frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fc <= '0;
    end else if (w_frame_tick) begin
      if (r_fc == FC_LAST) begin
        r_fc <= '0;
      end else begin
        r_fc <= r_fc + FC_W'(1);
      end
    end
  end

  assign sec_tick = w_frame_tick && (r_fc == FC_LAST);
`else
  assign sec_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen. Instance A keeps the full
// 800-pixel line but a 10-line frame so a whole frame fits in a short run.
// Instance B is tiny (14x8, TICK_DIV=3, 3 frames per second) for sec_tick.
module tb_vga_sync_gen;

  logic       clk;
  logic       a_rst_n;
  logic       b_rst_n;

  logic       a_pixel_tick, a_video_on, a_hsync_n, a_vsync_n, a_frame_tick, a_sec_tick;
  logic [9:0] a_pix_x, a_pix_y;
  logic       b_pixel_tick, b_video_on, b_hsync_n, b_vsync_n, b_frame_tick, b_sec_tick;
  logic [9:0] b_pix_x, b_pix_y;

  int errors = 0;
  int checks = 0;

`ifdef VGA_SYNC_SECOND_TICK_EN
  localparam int EXP_SEC_CNT = 2;
  localparam int EXP_SEC_POS = 36;
`else
  localparam int EXP_SEC_CNT = 0;
  localparam int EXP_SEC_POS = 0;
`endif

  vga_sync_gen #(
    .TICK_DIV(2), .H_DISPLAY(640), .H_FRONT(16), .H_RETRACE(96), .H_BACK(48),
    .V_DISPLAY(4), .V_FRONT(2), .V_RETRACE(2), .V_BACK(2), .FRAMES_PER_SEC(60)
  ) u_dut_a (
    .clk(clk), .reset_n(a_rst_n), .pixel_tick(a_pixel_tick),
    .pix_x(a_pix_x), .pix_y(a_pix_y), .video_on(a_video_on),
    .hsync_n(a_hsync_n), .vsync_n(a_vsync_n),
    .frame_tick(a_frame_tick), .sec_tick(a_sec_tick)
  );

  vga_sync_gen #(
    .TICK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_RETRACE(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1), .FRAMES_PER_SEC(3)
  ) u_dut_b (
    .clk(clk), .reset_n(b_rst_n), .pixel_tick(b_pixel_tick),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .video_on(b_video_on),
    .hsync_n(b_hsync_n), .vsync_n(b_vsync_n),
    .frame_tick(b_frame_tick), .sec_tick(b_sec_tick)
  );

  // Clock: 10 ns period; outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance falling edge by falling edge until instance A reaches (x,y).
  task automatic wait_xy(input int x, input int y, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(a_pix_x == 10'(x) && a_pix_y == 10'(y)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_%0d_%0d", x, y), 32'(a_pix_x == 10'(x) && a_pix_y == 10'(y)), 1);
  endtask

  initial begin
    int n, ticks, hlow, vlow, first_tick, fcnt, scnt, sec_pos, orphan;

    // Reset state
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel_tick", 32'(a_pixel_tick), 0);
    chk("rst_pix_x",      32'(a_pix_x),      0);
    chk("rst_pix_y",      32'(a_pix_y),      0);
    chk("rst_video_on",   32'(a_video_on),   1);
    chk("rst_hsync_n",    32'(a_hsync_n),    1);
    chk("rst_vsync_n",    32'(a_vsync_n),    1);
    chk("rst_frame_tick", 32'(a_frame_tick), 0);
    chk("rst_sec_tick",   32'(a_sec_tick),   0);
    chk("rst_b_frame",    32'(b_frame_tick), 0);

    // Release: first strobe in the second clk cycle, first advance after it
    a_rst_n = 1'b1;
    #1;
    chk("rel_cycle1_tick", 32'(a_pixel_tick), 0);
    @(negedge clk);
    chk("rel_cycle2_tick", 32'(a_pixel_tick), 1);
    chk("rel_cycle2_x",    32'(a_pix_x),      0);
    @(negedge clk);
    chk("rel_cycle3_tick", 32'(a_pixel_tick), 0);
    chk("rel_cycle3_x",    32'(a_pix_x),      1);

    // Horizontal edges on line 0
    wait_xy(639, 0, 4000);
    chk("video_on_639", 32'(a_video_on), 1);
    wait_xy(640, 0, 4000);
    chk("video_on_640", 32'(a_video_on), 0);
    chk("hsync_640",    32'(a_hsync_n),  1);
    wait_xy(655, 0, 4000);
    chk("hsync_655", 32'(a_hsync_n), 1);
    wait_xy(656, 0, 4000);
    chk("hsync_656", 32'(a_hsync_n), 0);
    wait_xy(751, 0, 4000);
    chk("hsync_751", 32'(a_hsync_n), 0);
    wait_xy(752, 0, 4000);
    chk("hsync_752", 32'(a_hsync_n), 1);

    // One full line: 800 strobes in 1600 clk, 96 of them with hsync low
    wait_xy(0, 1, 4000);
    ticks = 0;
    hlow  = 0;
    repeat (1600) begin
      if (a_pixel_tick) ticks++;
      if (a_pixel_tick && !a_hsync_n) hlow++;
      @(negedge clk);
    end
    chk("line_ticks",      32'(ticks),   800);
    chk("line_hsync_low",  32'(hlow),    96);
    chk("line_end_x",      32'(a_pix_x), 0);
    chk("line_end_y",      32'(a_pix_y), 2);

    // Vertical edges: visible lines 0..3, vsync on lines 6..7
    wait_xy(0, 3, 4000);
    chk("video_on_y3", 32'(a_video_on), 1);
    wait_xy(0, 4, 4000);
    chk("video_on_y4", 32'(a_video_on), 0);
    wait_xy(799, 5, 4000);
    chk("vsync_y5", 32'(a_vsync_n), 1);
    wait_xy(0, 6, 4000);
    chk("vsync_y6", 32'(a_vsync_n), 0);
    wait_xy(799, 7, 4000);
    chk("vsync_y7", 32'(a_vsync_n), 0);
    wait_xy(0, 8, 4000);
    chk("vsync_y8", 32'(a_vsync_n), 1);

    // Frame end: frame_tick at (799,9), then both counters wrap together
    n = 0;
    while (!a_frame_tick && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_seen", 32'(a_frame_tick), 1);
    chk("frame_tick_x",    32'(a_pix_x),      799);
    chk("frame_tick_y",    32'(a_pix_y),      9);
    chk("frame_tick_pix",  32'(a_pixel_tick), 1);
    @(negedge clk);
    chk("wrap_x",          32'(a_pix_x),      0);
    chk("wrap_y",          32'(a_pix_y),      0);
    chk("wrap_frame_tick", 32'(a_frame_tick), 0);
    chk("wrap_video_on",   32'(a_video_on),   1);

    // Next frame_tick exactly one frame later; vsync low for 2 lines of strobes
    n    = 0;
    vlow = 0;
    while (!a_frame_tick && n < 20000) begin
      if (a_pixel_tick && !a_vsync_n) vlow++;
      @(negedge clk);
      n++;
    end
    chk("frame_period_clk", 32'(n + 1), 16000);
    chk("frame_vsync_low",  32'(vlow),  1600);

    // Asynchronous reset mid-line while hsync is active
    wait_xy(700, 1, 20000);
    chk("mid_hsync_active", 32'(a_hsync_n), 0);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("async_hsync_n", 32'(a_hsync_n),    1);
    chk("async_pix_x",   32'(a_pix_x),      0);
    chk("async_pix_y",   32'(a_pix_y),      0);
    chk("async_tick",    32'(a_pixel_tick), 0);
    @(negedge clk);
    a_rst_n = 1'b1;

    // Instance B: 6 frames of 336 clk each; sec_tick on frames 3 and 6 if enabled
    b_rst_n    = 1'b1;
    first_tick = -1;
    fcnt       = 0;
    scnt       = 0;
    sec_pos    = 0;
    orphan     = 0;
    for (int k = 1; k <= 2016; k++) begin
      @(negedge clk);
      if (b_pixel_tick && first_tick < 0) first_tick = k;
      if (b_frame_tick) fcnt++;
      if (b_sec_tick) begin
        scnt++;
        sec_pos = sec_pos * 10 + fcnt;
        if (!b_frame_tick) orphan++;
      end
    end
    chk("b_first_tick",  32'(first_tick), 2);
    chk("b_frame_count", 32'(fcnt),       6);
    chk("b_sec_count",   32'(scnt),       EXP_SEC_CNT);
    chk("b_sec_frames",  32'(sec_pos),    EXP_SEC_POS);
    chk("b_sec_orphan",  32'(orphan),     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
